jk_cmd_gen: RTL

//  Command generator that drives a bank of WIDTH JK flip-flops (same clk/rst) with per-bit
//  {j,k} excitation codes. Accepts a target/count request via valid/ready, issues the codes,

---
 rtl/jk_cmd_gen_pkg.sv | 40 ++++
 rtl/jk_cmd_gen_excite.sv | 25 ++
 rtl/jk_cmd_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_gen_pkg.sv
// Shared encodings for the JK bank command generator: per-bit excitation
// codes ({j,k} bit order), request modes and controller states.
package jk_cmd_gen_pkg;

  // Per-bit excitation codes, bit order {j,k}
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_code_e;

  // Request modes carried on tgt_mode
  typedef enum logic [1:0] {
    MODE_LOAD_EXPL = 2'b00,
    MODE_LOAD_TGL  = 2'b01,
    MODE_COUNT     = 2'b10,
    MODE_CLEAR     = 2'b11
  } mode_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_CHECK = 2'b10
  } state_e;

  // Excitation for one flip-flop moving from c to n. Explicit mode always
  // drives SET/RESET; otherwise only differing bits toggle.
  function automatic logic [1:0] jk_bit_code(input logic c, input logic n, input logic f);
    logic [1:0] code;
    if (f) begin
      code = n ? JK_SET : JK_RESET;
    end else begin
      code = (c ^ n) ? JK_TOGGLE : JK_HOLD;
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_cmd_gen_excite.sv
// Combinational excitation encoder: turns a current/next bank value pair
// into per-bit {j,k} codes, either minimal (HOLD/TOGGLE) or explicit
// (SET/RESET on every bit).
module jk_excite
  import jk_cmd_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  input  logic             force_explicit,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // Per-bit code selection from the current/next value of each flip-flop
  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_bit_code(cur[i], nxt[i], force_explicit);
    end
  end

endmodule

// File: rtl/jk_cmd_gen.sv
// Command generator for a bank of JK flip-flops. Accepts one request at a
// time, drives registered {j,k} commands, keeps a shadow of the expected
// bank value and compares it against the bank outputs after each request.
module jk_cmd_gen
  import jk_cmd_gen_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [1:0]       tgt_mode,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] exp_q,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  state_e           state_nxt;
  mode_e            mode;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] exp_nxt;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] exc_nxt;
  logic             exc_force;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  assign mode      = mode_e'(tgt_mode);
  assign tgt_ready = (state == ST_IDLE);

  // Choose the target value of the next command: the request operand at
  // accept, otherwise the next count step from the shadow value
  always_comb begin
    exc_nxt   = exp_q + ONE;
    exc_force = 1'b0;
    if (state == ST_IDLE) begin
      case (mode)
        MODE_LOAD_EXPL: begin
          exc_nxt   = tgt_data;
          exc_force = 1'b1;
        end
        MODE_LOAD_TGL: begin
          exc_nxt   = tgt_data;
          exc_force = 1'b0;
        end
        MODE_CLEAR: begin
          exc_nxt   = '0;
          exc_force = 1'b1;
        end
        default: begin
          exc_nxt   = exp_q + ONE;
          exc_force = 1'b0;
        end
      endcase
    end else begin
      exc_nxt   = exp_q + ONE;
      exc_force = 1'b0;
    end
  end

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .cur            (exp_q),
    .nxt            (exc_nxt),
    .force_explicit (exc_force),
    .j              (exc_j),
    .k              (exc_k)
  );

  // Next-state and next-output logic; commands are HOLD unless issued here
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exp_nxt   = exp_q;
    j_nxt     = '0;
    k_nxt     = '0;
    done_nxt  = 1'b0;
    err_nxt   = err;
    case (state)
      ST_IDLE: begin
        if (tgt_valid) begin
          if ((mode == MODE_COUNT) && (tgt_data == '0)) begin
            state_nxt = ST_CHECK;
          end else begin
            state_nxt = ST_APPLY;
            j_nxt     = exc_j;
            k_nxt     = exc_k;
            exp_nxt   = exc_nxt;
          end
          cnt_nxt = (mode == MODE_COUNT) ? (tgt_data - ONE) : '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (cnt == '0) begin
          state_nxt = ST_CHECK;
        end else begin
          j_nxt   = exc_j;
          k_nxt   = exc_k;
          exp_nxt = exc_nxt;
          cnt_nxt = cnt - ONE;
        end
      end
      ST_CHECK: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
        if (CHECK_EN && (q_fb != exp_q)) begin
          err_nxt = 1'b1;
          exp_nxt = q_fb;
        end else begin
          err_nxt = err;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered commands, shadow value, step counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      exp_q <= '0;
      j     <= '0;
      k     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      exp_q <= exp_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule
